// File: rtl/dircc_mem_pkg.sv
// -----------------------------------------------------------------------------
// dircc_mem_pkg
// Shared definitions for the per-node memory master: default bus widths and
// the burst-engine state encoding.
// -----------------------------------------------------------------------------
package dircc_mem_pkg;

   localparam int ADDR_W_DEF = 15;   // memory word-address width
   localparam int DATA_W_DEF = 16;   // memory data width
   localparam int LEN_W_DEF  = 8;    // burst length field (beats minus one)

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WR       = 2'd1,
      ST_RD_ISSUE = 2'd2,
      ST_RD_DRAIN = 2'd3
   } state_t;

endpackage

// File: rtl/dircc_sync_fifo.sv
// -----------------------------------------------------------------------------
// dircc_sync_fifo
// Single-clock FIFO used as the read-return buffer. DEPTH must be a power of
// two (pointers wrap naturally). The occupancy count is exported so the
// issuing logic can compute read credits.
//
// Ports:
//   clk        clock
//   reset      synchronous active-high flush
//   push       write push_data (ignored when full)
//   push_data  data to enqueue
//   pop        consume head (ignored when empty)
//   pop_data   current head entry
//   empty      no entries stored
//   count      number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module dircc_sync_fifo #(
   parameter  int WIDTH = 16,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             full;
   logic             push_en;
   logic             pop_en;

   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));
   assign pop_en   = pop && !empty;
   assign push_en  = push && !full;
   assign pop_data = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
         // Simultaneous push and pop leaves the occupancy unchanged.
         case ({push_en, pop_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; a flush only clears the pointers
   // and count, which is all that is needed to make stale entries invisible.
   always_ff @(posedge clk) begin
      if (push_en) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/dircc_node_mem_master.sv
// -----------------------------------------------------------------------------
// dircc_node_mem_master
// Node-side initiator for one per-node memory port. Turns burst commands
// (base address + beats-1) into single-word accesses on a fixed-latency memory
// port with no waitrequest. Write data arrives on a valid/ready stream; read
// data leaves on a valid/ready stream buffered by a credit-limited FIFO so the
// consumer can apply backpressure without losing returning data.
//
// Ports:
//   clk_clk, reset_reset          clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/len burst command handshake
//   wr_valid/ready/data           write-beat stream (accepted only in WR)
//   rd_valid/ready/data           read-beat stream (FIFO head)
//   busy                          burst in progress
//   done                          one-cycle pulse at burst completion
//   mem_address/write/writedata   registered memory request
//   mem_readdata                  memory data, READ_LATENCY after address
// -----------------------------------------------------------------------------
module dircc_node_mem_master
   import dircc_mem_pkg::*;
#(
   parameter int ADDR_W        = ADDR_W_DEF,
   parameter int DATA_W        = DATA_W_DEF,
   parameter int LEN_W         = LEN_W_DEF,
   parameter int READ_LATENCY  = 1,
   parameter int RD_FIFO_DEPTH = 4
) (
   input  logic              clk_clk,
   input  logic              reset_reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_address,
   input  logic [DATA_W-1:0] mem_readdata,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata
);

   localparam int PIPE_W = READ_LATENCY + 1;
   localparam int CNT_W  = $clog2(RD_FIFO_DEPTH) + 1;
   localparam int CR_W   = CNT_W + 1;   // holds fifo_count + inflight

   state_t            state;
   logic [ADDR_W-1:0] base;
   logic [LEN_W-1:0]  last_idx;         // beat count minus one
   logic [LEN_W-1:0]  idx;
   logic [ADDR_W-1:0] cur_addr;
   logic [PIPE_W-1:0] rd_pipe;          // one bit per outstanding read
   logic [CR_W-1:0]   inflight;
   logic [CR_W-1:0]   credit_used;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty;
   logic              issue;

   // Wraps modulo 2^ADDR_W by construction of the adder width.
   assign cur_addr  = base + ADDR_W'(idx);

   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign wr_ready  = (state == ST_WR);
   assign rd_valid  = !fifo_empty;

   // NOTE: every variable written in a combinational block gets a default at
   // the top so no path can leave it unassigned and infer a latch.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < PIPE_W; i++) begin
         inflight = inflight + CR_W'(rd_pipe[i]);
      end
   end

   // A read may only be issued if its data is guaranteed a FIFO slot: stored
   // entries plus reads still travelling through the memory must leave room.
   assign credit_used = CR_W'(fifo_count) + inflight;
   assign issue       = (state == ST_RD_ISSUE) && (credit_used < CR_W'(RD_FIFO_DEPTH));

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state         <= ST_IDLE;
         base          <= '0;
         last_idx      <= '0;
         idx           <= '0;
         mem_address   <= '0;
         mem_write     <= 1'b0;
         mem_writedata <= '0;
         done          <= 1'b0;
         rd_pipe       <= '0;
      end else begin
         mem_write <= 1'b0;
         done      <= 1'b0;
         // The top bit of the pipe lines up with mem_readdata being valid.
         rd_pipe   <= {rd_pipe[PIPE_W-2:0], issue};

         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  base     <= cmd_addr;
                  last_idx <= cmd_len;
                  idx      <= '0;
                  state    <= cmd_write ? ST_WR : ST_RD_ISSUE;
               end
            end

            ST_WR: begin
               if (wr_valid) begin
                  mem_write     <= 1'b1;
                  mem_address   <= cur_addr;
                  mem_writedata <= wr_data;
                  idx           <= idx + 1'b1;
                  // done and the final mem_write appear together, already in IDLE.
                  if (idx == last_idx) begin
                     done  <= 1'b1;
                     state <= ST_IDLE;
                  end
               end
            end

            ST_RD_ISSUE: begin
               if (issue) begin
                  mem_address <= cur_addr;
                  idx         <= idx + 1'b1;
                  if (idx == last_idx) state <= ST_RD_DRAIN;
               end
            end

            ST_RD_DRAIN: begin
               // Finished once nothing is in flight and the consumer took the last beat.
               if ((inflight == '0) && fifo_empty) begin
                  done  <= 1'b1;
                  state <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   dircc_sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (RD_FIFO_DEPTH)
   ) u_rd_fifo (
      .clk       (clk_clk),
      .reset     (reset_reset),
      .push      (rd_pipe[PIPE_W-1]),
      .push_data (mem_readdata),
      .pop       (rd_ready),
      .pop_data  (rd_data),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_dircc_node_mem_master.sv
// -----------------------------------------------------------------------------
// tb_dircc_node_mem_master
// Self-checking bench: a behavioural memory with configurable read latency,
// scoreboards for expected memory writes and expected read beats, and a
// negedge monitor that compares DUT activity against them.
// -----------------------------------------------------------------------------
module tb_dircc_node_mem_master;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 16;
   localparam int LEN_W  = 8;
   localparam int RL     = 3;
   localparam int DEPTH  = 4;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_exp_t;

   logic              clk_clk = 1'b0;
   logic              reset_reset;
   logic              cmd_valid, cmd_ready, cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [LEN_W-1:0]  cmd_len;
   logic              wr_valid, wr_ready;
   logic [DATA_W-1:0] wr_data;
   logic              rd_valid, rd_ready;
   logic [DATA_W-1:0] rd_data;
   logic              busy, done;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_readdata;
   logic              mem_write;
   logic [DATA_W-1:0] mem_writedata;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   wr_exp_t           wr_q[$];
   logic [DATA_W-1:0] rd_q[$];
   int                wr_cycles[$];
   int                done_cnt   = 0;
   int                done_cyc   = -1;
   int                rd_pops    = 0;
   int                cr_max     = 0;
   bit                mon_rd_en  = 1'b1;
   bit                rd_throttle = 1'b0;

   logic [DATA_W-1:0] tb_mem  [0:(1<<ADDR_W)-1];   // memory seen by the DUT
   logic [DATA_W-1:0] exp_mem [0:(1<<ADDR_W)-1];   // bench's own expectation
   logic [DATA_W-1:0] rpipe   [RL];

   always #5 clk_clk = ~clk_clk;
   always @(posedge clk_clk) cyc <= cyc + 1;

   dircc_node_mem_master #(
      .ADDR_W        (ADDR_W),
      .DATA_W        (DATA_W),
      .LEN_W         (LEN_W),
      .READ_LATENCY  (RL),
      .RD_FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_clk       (clk_clk),
      .reset_reset   (reset_reset),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_write     (cmd_write),
      .cmd_addr      (cmd_addr),
      .cmd_len       (cmd_len),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .wr_data       (wr_data),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .rd_data       (rd_data),
      .busy          (busy),
      .done          (done),
      .mem_address   (mem_address),
      .mem_readdata  (mem_readdata),
      .mem_write     (mem_write),
      .mem_writedata (mem_writedata)
   );

   // Fixed-latency memory: data for the address presented in cycle c is on
   // mem_readdata during cycle c+RL.
   always @(posedge clk_clk) begin
      rpipe[0] <= tb_mem[mem_address];
      for (int k = 1; k < RL; k++) rpipe[k] <= rpipe[k-1];
      if (mem_write && !reset_reset) tb_mem[mem_address] <= mem_writedata;
   end
   assign mem_readdata = rpipe[RL-1];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk_clk);
      #1;
   endtask

   // Monitor: sampled mid-cycle, away from the active edge.
   always @(negedge clk_clk) begin
      if (!reset_reset) begin
         if (mem_write) begin
            wr_cycles.push_back(cyc);
            if (wr_q.size() == 0) begin
               check("wr_unexpected", wr_q.size() != 0, 1'b1);
            end else begin
               wr_exp_t e;
               e = wr_q.pop_front();
               check("wr_addr", mem_address, e.addr);
               check("wr_data", mem_writedata, e.data);
            end
         end
         if (rd_valid && mon_rd_en) begin
            if (rd_q.size() == 0) begin
               check("rd_unexpected", rd_q.size() != 0, 1'b1);
            end else begin
               check("rd_data", rd_data, rd_q[0]);
               if (rd_ready) begin
                  void'(rd_q.pop_front());
                  rd_pops++;
               end
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_cmd_ready", cmd_ready, 1'b1);
            check("done_busy", busy, 1'b0);
            check("done_rd_pending", rd_q.size(), 0);
            check("done_wr_pending", wr_q.size(), 0);
         end
         if (int'(dut.fifo_count) + int'(dut.inflight) > cr_max)
            cr_max = int'(dut.fifo_count) + int'(dut.inflight);
      end
   end

   // Read-side consumer: always ready, or ready one cycle in three.
   initial begin
      rd_ready = 1'b0;
      forever begin
         @(posedge clk_clk);
         #1;
         rd_ready = rd_throttle ? (cyc % 3 == 0) : 1'b1;
      end
   end

   task automatic send_cmd(input logic wr, input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
      logic ok = 1'b0;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_len   = len;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk_clk);
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check("cmd_accept", ok, 1'b1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic write_burst(input logic [ADDR_W-1:0] addr, input int len, input int gap,
                              input logic [DATA_W-1:0] d0);
      for (int i = 0; i <= len; i++) begin
         logic [ADDR_W-1:0] a;
         logic              ok;
         a  = addr + ADDR_W'(i);
         ok = 1'b0;
         if (gap > 0 && i > 0) begin
            wr_valid = 1'b0;
            repeat (gap) tick();
         end
         wr_valid = 1'b1;
         wr_data  = d0 + DATA_W'(i);
         wr_q.push_back('{a, wr_data});
         exp_mem[a] = wr_data;
         for (int k = 0; k < 200; k++) begin
            @(negedge clk_clk);
            if (wr_ready) begin
               ok = 1'b1;
               break;
            end
         end
         check("wr_accept", ok, 1'b1);
         tick();
      end
      wr_valid = 1'b0;
   endtask

   task automatic read_burst(input logic [ADDR_W-1:0] addr, input int len);
      for (int i = 0; i <= len; i++) rd_q.push_back(exp_mem[addr + ADDR_W'(i)]);
      send_cmd(1'b0, addr, LEN_W'(len));
   endtask

   task automatic wait_done(input string tag, input int target, input int budget);
      for (int k = 0; k < budget; k++) begin
         if (done_cnt >= target) break;
         tick();
      end
      check(tag, done_cnt, target);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_mem_address"},   mem_address,   '0);
      check({pfx, "_mem_write"},     mem_write,     1'b0);
      check({pfx, "_mem_writedata"}, mem_writedata, '0);
      check({pfx, "_rd_valid"},      rd_valid,      1'b0);
      check({pfx, "_wr_ready"},      wr_ready,      1'b0);
      check({pfx, "_done"},          done,          1'b0);
      check({pfx, "_busy"},          busy,          1'b0);
      check({pfx, "_cmd_ready"},     cmd_ready,     1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, d0, p0, acc_cyc;
      bit acc;

      for (int i = 0; i < (1 << ADDR_W); i++) begin
         tb_mem[i]  = DATA_W'(i * 3) ^ 16'h5A5A;
         exp_mem[i] = DATA_W'(i * 3) ^ 16'h5A5A;
      end
      reset_reset = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_valid  = 1'b0; wr_data   = '0;
      repeat (3) tick();
      check_reset_outputs("rst");
      reset_reset = 1'b0;
      tick();

      // 1: 4-beat back-to-back write at 0x0010.
      n0 = wr_cycles.size();
      d0 = done_cnt;
      send_cmd(1'b1, 15'h0010, 8'd3);
      write_burst(15'h0010, 3, 0, 16'h00A0);
      wait_done("t1_done", d0 + 1, 50);
      check("t1_nwrites", wr_cycles.size() - n0, 4);
      if (wr_cycles.size() >= n0 + 4) begin
         for (int i = 1; i < 4; i++) check("t1_consecutive", wr_cycles[n0+i] - wr_cycles[n0+i-1], 1);
         check("t1_done_with_last", done_cyc, wr_cycles[n0+3]);
      end

      // 2: read the same four words back with rd_ready held high.
      n0 = wr_cycles.size();
      d0 = done_cnt;
      p0 = rd_pops;
      read_burst(15'h0010, 3);
      wait_done("t2_done", d0 + 1, 100);
      check("t2_beats", rd_pops - p0, 4);
      check("t2_no_write", wr_cycles.size() - n0, 0);

      // 3: 256-beat read with a slow consumer; credits must bound occupancy.
      cr_max = 0;
      d0 = done_cnt;
      p0 = rd_pops;
      rd_throttle = 1'b1;
      read_burst(15'h1000, 255);
      wait_done("t3_done", d0 + 1, 3000);
      rd_throttle = 1'b0;
      check("t3_beats", rd_pops - p0, 256);
      check("t3_credit_le_depth", cr_max <= DEPTH, 1'b1);
      check("t3_credit_used", cr_max > 0, 1'b1);

      // 4: write across the top of the address space, then read it back.
      d0 = done_cnt;
      send_cmd(1'b1, 15'h7FFF, 8'd1);
      write_burst(15'h7FFF, 1, 0, 16'hBEE0);
      wait_done("t4_wr_done", d0 + 1, 50);
      read_burst(15'h7FFF, 1);
      wait_done("t4_rd_done", d0 + 2, 100);

      // 5: reset in the middle of a 16-beat read.
      d0 = done_cnt;
      p0 = rd_pops;
      read_burst(15'h0200, 15);
      for (int k = 0; k < 200; k++) begin
         if (rd_pops - p0 >= 5) break;
         tick();
      end
      check("t5_partial", rd_pops - p0, 5);
      mon_rd_en   = 1'b0;
      reset_reset = 1'b1;
      rd_q.delete();
      tick();
      check_reset_outputs("t5");
      reset_reset = 1'b0;
      mon_rd_en   = 1'b1;
      repeat (8) tick();
      check("t5_no_done", done_cnt, d0);
      check("t5_rd_idle", rd_valid, 1'b0);
      send_cmd(1'b1, 15'h0100, 8'd0);
      write_burst(15'h0100, 0, 0, 16'h1234);
      wait_done("t5_wr_done", d0 + 1, 50);

      // 6: gapped write with the next command already waiting.
      d0 = done_cnt;
      n0 = wr_cycles.size();
      acc_cyc = -1;
      send_cmd(1'b1, 15'h0300, 8'd2);
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 15'h0400;
      cmd_len   = 8'd0;
      fork
         write_burst(15'h0300, 2, 2, 16'hC000);
         begin
            acc = 1'b0;
            for (int k = 0; k < 200; k++) begin
               @(negedge clk_clk);
               if (cmd_ready) begin
                  acc     = 1'b1;
                  acc_cyc = cyc;
                  break;
               end
            end
            tick();
            cmd_valid = 1'b0;
            check("t6_second_accept", acc, 1'b1);
         end
      join
      check("t6_first_done", done_cnt, d0 + 1);
      check("t6_accept_in_done_cycle", acc_cyc, done_cyc);
      check("t6_nwrites", wr_cycles.size() - n0, 3);
      if (wr_cycles.size() >= n0 + 3) begin
         check("t6_gap1", wr_cycles[n0+1] - wr_cycles[n0], 3);
         check("t6_gap2", wr_cycles[n0+2] - wr_cycles[n0+1], 3);
      end
      write_burst(15'h0400, 0, 0, 16'hD00D);
      wait_done("t6_second_done", d0 + 2, 50);
      read_burst(15'h0300, 2);
      wait_done("t6_readback", d0 + 3, 100);

      repeat (5) tick();
      check("end_rd_empty", rd_q.size(), 0);
      check("end_wr_empty", wr_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dircc_node_mem_master.md
Name: dircc_node_mem_master

Overview:
- Node-side initiator for one per-node memory port of the GALS test system: drives mem_address/mem_write/mem_writedata and consumes mem_readdata.
- Converts burst commands (base address + length) into single-word memory accesses.
- Write data enters and read data leaves on valid/ready streams. Read return is backpressured through a credit-limited FIFO, because the memory port has fixed read latency and no waitrequest.

Parameters:
- ADDR_W, 15, memory word-address width
- DATA_W, 16, memory data width
- LEN_W, 8, burst length field; beat count = cmd_len+1 (1..256)
- READ_LATENCY, 1, cycles from mem_address presented to mem_readdata valid (legal 1..3)
- RD_FIFO_DEPTH, 4, read-return FIFO entries; power of 2, >= READ_LATENCY+1

Ports:
- clk_clk  in  1  system clock; single clock domain
- reset_reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted on valid&ready
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  burst base word address
- cmd_len  in  LEN_W  beats minus one
- wr_valid  in  1  write beat offered
- wr_ready  out  1  write beat accepted
- wr_data  in  DATA_W  write beat data
- rd_valid  out  1  read beat available
- rd_ready  in  1  read beat consumed
- rd_data  out  DATA_W  read beat data
- busy  out  1  burst in progress (state != IDLE)
- done  out  1  one-cycle pulse at burst completion
- mem_address  out  ADDR_W  memory word address (registered)
- mem_readdata  in  DATA_W  memory read data, READ_LATENCY after address
- mem_write  out  1  write strobe (registered)
- mem_writedata  out  DATA_W  write data (registered)

Behaviour:
- Reset values:
  - mem_address = 0, mem_write = 0, mem_writedata = 0.
  - rd_valid = 0, wr_ready = 0, done = 0, busy = 0.
  - cmd_ready = 1 (IDLE); FIFO empty; in-flight shift register cleared.
- States: IDLE, WR, RD_ISSUE, RD_DRAIN.
- cmd_ready = (state == IDLE). A command offered while busy is held off, not dropped.
- On cmd accept: latch base and beat count = cmd_len+1, clear index. Go to WR if cmd_write, else RD_ISSUE.
- Address arithmetic: base + index, modulo 2^ADDR_W (0x7FFF+1 -> 0x0000).
- WR:
  - wr_ready = 1.
  - Each wr handshake registers mem_write = 1, mem_address = base+idx and mem_writedata = wr_data, visible the next cycle (1-cycle latency).
  - mem_write = 0 in any cycle without a preceding handshake; wr_valid gaps are legal.
  - done pulses in the same cycle as the last mem_write. State returns to IDLE that cycle, so cmd_ready = 1 in that cycle.
- RD_ISSUE:
  - mem_write = 0.
  - Issue a read when fifo_count + inflight < RD_FIFO_DEPTH: register mem_address = base+idx and shift a 1 into a valid pipe of length READ_LATENCY+1.
  - The pipe output pushes mem_readdata into the FIFO. Credits guarantee the FIFO never overflows.
  - After the last issue, go to RD_DRAIN.
- RD_DRAIN: when inflight == 0 and the FIFO is empty (last beat accepted), pulse done and go to IDLE.
- Read stream:
  - rd_valid = FIFO not empty; rd_data = FIFO head.
  - rd_data is stable while rd_valid & !rd_ready.
  - Simultaneous push and pop keeps the count unchanged.
- mem_address holds its last value when not issuing; only mem_write qualifies writes.
- Reset mid-burst: takes effect next cycle regardless of state. In-flight reads are discarded, the FIFO is flushed, no done pulse is produced and no spurious mem_write occurs.
- rd_ready asserted with the FIFO empty is ignored. wr_valid outside WR is ignored (wr_ready = 0).

Decomposition:
- Package dircc_mem_pkg holds:
  - ADDR_W/DATA_W/LEN_W defaults
  - the state enum typedef (IDLE, WR, RD_ISSUE, RD_DRAIN)
- Sub-module dircc_sync_fifo implements the read-return FIFO.
  - Parameterised width and depth.
  - Exposes count for credit computation.
  - Synchronous active-high flush on reset.

Test Plan:
1. Write cmd addr=0x0010 len=3, wr_data A0..A3 back-to-back -> mem_write high 4 consecutive cycles at 0x0010..0x0013 with A0..A3; done once with the 4th; cmd_ready = 1 that cycle.
2. Read cmd addr=0x0010 len=3 against a memory model (READ_LATENCY=1, preloaded from test 1), rd_ready=1 -> rd_data A0..A3 in order; done after the 4th rd handshake; mem_write stays 0.
3. Read len=255 with rd_ready high 1 cycle in 3 and READ_LATENCY=3, RD_FIFO_DEPTH=4 -> 256 beats in order, none lost or duplicated; assert fifo_count+inflight <= 4 every cycle.
4. Write 2 words at 0x7FFF -> mem_address 0x7FFF then 0x0000; read back at the same base returns identical data.
5. Reset asserted after 5 of 16 read beats delivered -> next cycle all outputs at reset values, no done; a following write of len=0 at 0x0100 completes normally.
6. Write len=2 with wr_valid gaps of 2 cycles, plus cmd_valid held high during the burst -> 3 mem_write pulses matching the gaps; second command accepted only after done.
